// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter, MSB-first, with optional
// repetitions separated by GAP_CYC idle cycles.
// Optional feature macro: SEQ_PATTERN_TX_ERR_INJ_EN (single-bit error injection
// on the first copy, adds inputs inj_en and inj_idx).
module seq_pattern_tx #(
   parameter int unsigned PAT_W   = 8,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned REP_W   = 4,
   parameter int unsigned GAP_CYC = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] reps,
   input  logic             abort,
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
   input  logic             inj_en,
   input  logic [LEN_W-1:0] inj_idx,
`endif
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [REP_W-1:0]   reps_q, reps_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               x_q, x_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [LEN_W-1:0]   top_in;
   logic [LEN_W-1:0]   top_lat;
   logic [LEN_W-1:0]   nxt_idx;
   logic               len_ok;
   logic               inj_start;
   logic               inj_shift;

`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
   logic               first_q, first_d;
   logic               inj_en_q, inj_en_d;
   logic [LEN_W-1:0]   inj_idx_q, inj_idx_d;
`endif

   // Select bit idx of pat (shift keeps the index width independent of PAT_W),
   // optionally inverted.
   function automatic logic pick_bit(input logic [PAT_W-1:0] pat,
                                     input logic [LEN_W-1:0] idx,
                                     input logic             flip);
      logic [PAT_W-1:0] sh;
      sh = pat >> idx;
      return sh[0] ^ flip;
   endfunction

   assign top_in  = len - LEN_W'(1);
   assign top_lat = len_q - LEN_W'(1);
   assign nxt_idx = idx_q - LEN_W'(1);
   assign len_ok  = (len != '0) && (32'(len) <= PAT_W);

`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
   // Injection only ever targets the first copy; indices >= len never match.
   assign inj_start = inj_en & (top_in == inj_idx);
   assign inj_shift = inj_en_q & first_q & (nxt_idx == inj_idx_q);
`else
   assign inj_start = 1'b0;
   assign inj_shift = 1'b0;
`endif

   // State register plus latched transfer parameters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         reps_q    <= '0;
         idx_q     <= '0;
         gap_q     <= '0;
         x_q       <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
         first_q   <= 1'b0;
         inj_en_q  <= 1'b0;
         inj_idx_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         reps_q    <= reps_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         x_q       <= x_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
         first_q   <= first_d;
         inj_en_q  <= inj_en_d;
         inj_idx_q <= inj_idx_d;
`endif
      end
   end

   // Next-state logic; the next output bit is computed here so x is a flop.
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      len_d     = len_q;
      reps_d    = reps_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      x_d       = 1'b0;
      valid_d   = 1'b0;
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
      first_d   = first_q;
      inj_en_d  = inj_en_q;
      inj_idx_d = inj_idx_q;
`endif

      case (state_q)
         IDLE: begin
            if (start && !abort && len_ok) begin
               pat_d   = pattern;
               len_d   = len;
               reps_d  = reps;
               idx_d   = top_in;
               x_d     = pick_bit(pattern, top_in, inj_start);
               valid_d = 1'b1;
               state_d = SHIFT;
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
               first_d   = 1'b1;
               inj_en_d  = inj_en;
               inj_idx_d = inj_idx;
`endif
            end
         end

         SHIFT: begin
            if (idx_q != '0) begin
               idx_d   = nxt_idx;
               x_d     = pick_bit(pat_q, nxt_idx, inj_shift);
               valid_d = 1'b1;
            end else if (reps_q != '0) begin
               reps_d = reps_q - REP_W'(1);
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
               first_d = 1'b0;
`endif
               if (GAP_CYC > 0) begin
                  gap_d   = GAP_W'(GAP_CYC - 1);
                  state_d = GAP;
               end else begin
                  // No gap: restart the next copy on the very next cycle.
                  idx_d   = top_lat;
                  x_d     = pick_bit(pat_q, top_lat, 1'b0);
                  valid_d = 1'b1;
               end
            end else begin
               state_d = DONE;
            end
         end

         GAP: begin
            if (gap_q == '0) begin
               idx_d   = top_lat;
               x_d     = pick_bit(pat_q, top_lat, 1'b0);
               valid_d = 1'b1;
               state_d = SHIFT;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides every transition out of a busy state.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         x_d     = 1'b0;
         valid_d = 1'b0;
      end
   end

   // Status flags follow the next state so they are registered with x/valid.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign x     = x_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance with GAP_CYC=2 and one
// with GAP_CYC=0. Expected {x,valid,busy,done} per cycle are queued by the
// stimulus and popped by per-instance monitors on the falling edge.
module tb_seq_pattern_tx;

   localparam logic [3:0] E_IDLE = 4'b0000;
   localparam logic [3:0] E_GAP  = 4'b0010;
   localparam logic [3:0] E_DONE = 4'b0011;

   logic       clk;
   logic       reset_n;
   logic       start2, start0;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] reps;
   logic       abort;
   logic       inj_en;
   logic [3:0] inj_idx;
   logic       x2, v2, b2, d2;
   logic       x0, v0, b0, d0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [3:0] q2[$];
   logic [3:0] q0[$];

   seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYC(2)) dut_g2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .pattern(pattern),
      .len(len), .reps(reps), .abort(abort),
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
      .inj_en(inj_en), .inj_idx(inj_idx),
`endif
      .x(x2), .valid(v2), .busy(b2), .done(d2));

   seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .REP_W(4), .GAP_CYC(0)) dut_g0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .pattern(pattern),
      .len(len), .reps(reps), .abort(abort),
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
      .inj_en(inj_en), .inj_idx(inj_idx),
`endif
      .x(x0), .valid(v0), .busy(b0), .done(d0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitors: compare one queued expectation per cycle.
   always @(negedge clk) begin
      logic [3:0] e;
      if (q2.size() > 0) begin
         e = q2.pop_front();
         n_checks++;
         if ({x2, v2, b2, d2} !== e) begin
            n_fail++;
            $display("FAIL g2_out cyc=%0d got xvbd=%b required %b", cyc, {x2, v2, b2, d2}, e);
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         n_checks++;
         if ({x0, v0, b0, d0} !== e) begin
            n_fail++;
            $display("FAIL g0_out cyc=%0d got xvbd=%b required %b", cyc, {x0, v0, b0, d0}, e);
         end
      end
   end

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s got xvbd=%b required %b", name, got, req);
      end
   endtask

   task automatic push2_bits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) q2.push_back({bits[i], 3'b110});
   endtask

   task automatic push0_bits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) q0.push_back({bits[i], 3'b110});
   endtask

   task automatic push2_n(input logic [3:0] e, input int n);
      for (int i = 0; i < n; i++) q2.push_back(e);
   endtask

   task automatic begin_start(input logic which0, input logic [7:0] p,
                              input logic [3:0] l, input logic [3:0] r);
      @(negedge clk);
      #1;
      pattern = p;
      len     = l;
      reps    = r;
      if (which0) start0 = 1'b1;
      else        start2 = 1'b1;
   endtask

   // Drop start and scramble the inputs to show only latched values matter.
   task automatic end_start;
      @(negedge clk);
      #1;
      start2  = 1'b0;
      start0  = 1'b0;
      pattern = ~pattern;
      len     = 4'd8;
      reps    = 4'd15;
   endtask

   task automatic drain;
      int t;
      t = 0;
      while ((q2.size() != 0 || q0.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 200) begin
         n_fail++;
         $display("FAIL drain_timeout got pending=%0d required 0", q2.size() + q0.size());
         q2.delete();
         q0.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got running required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      start2  = 1'b0;
      start0  = 1'b0;
      pattern = '0;
      len     = '0;
      reps    = '0;
      abort   = 1'b0;
      inj_en  = 1'b0;
      inj_idx = '0;

      // Power-on reset
      #2 reset_n = 1'b0;
      #1;
      check("reset_g2", {x2, v2, b2, d2}, E_IDLE);
      check("reset_g0", {x0, v0, b0, d0}, E_IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 reset_n = 1'b1;
      push2_n(E_IDLE, 2);
      q0.push_back(E_IDLE);
      q0.push_back(E_IDLE);
      drain();

      // Single copy 101011, done on cycle 7, idle on cycle 8
      begin_start(1'b0, 8'b0010_1011, 4'd6, 4'd0);
      push2_bits(8'b0010_1011, 6);
      q2.push_back(E_DONE);
      q2.push_back(E_IDLE);
      end_start();
      drain();

      // Three copies of 101 with two-cycle gaps (14 cycles to done)
      begin_start(1'b0, 8'b0000_0101, 4'd3, 4'd2);
      push2_bits(8'b101, 3);
      push2_n(E_GAP, 2);
      push2_bits(8'b101, 3);
      push2_n(E_GAP, 2);
      push2_bits(8'b101, 3);
      q2.push_back(E_DONE);
      q2.push_back(E_IDLE);
      end_start();
      drain();

      // Back-to-back copies, start during SHIFT ignored
      begin_start(1'b1, 8'b0000_0010, 4'd2, 4'd1);
      push0_bits(8'b1010, 4);
      q0.push_back(E_DONE);
      q0.push_back(E_IDLE);
      end_start();
      start0  = 1'b1;
      pattern = 8'hFF;
      len     = 4'd8;
      @(negedge clk);
      #1 start0 = 1'b0;
      drain();

      // Abort on the third bit of F0
      begin_start(1'b0, 8'hF0, 4'd8, 4'd0);
      push2_bits(8'b111, 3);
      end_start();
      repeat (2) @(negedge clk);
      #1 abort = 1'b1;
      push2_n(E_IDLE, 3);
      @(negedge clk);
      #1 abort = 1'b0;
      drain();

      // Fresh start accepted after abort
      begin_start(1'b0, 8'h03, 4'd2, 4'd0);
      push2_bits(8'b11, 2);
      q2.push_back(E_DONE);
      q2.push_back(E_IDLE);
      end_start();
      drain();

      // start together with abort in IDLE is not accepted
      @(negedge clk);
      #1;
      abort   = 1'b1;
      start2  = 1'b1;
      pattern = 8'hFF;
      len     = 4'd8;
      push2_n(E_IDLE, 3);
      @(negedge clk);
      #1;
      abort  = 1'b0;
      start2 = 1'b0;
      drain();

      // Illegal lengths 0 and 9 are ignored
      begin_start(1'b0, 8'hFF, 4'd0, 4'd0);
      push2_n(E_IDLE, 3);
      end_start();
      drain();
      begin_start(1'b0, 8'hFF, 4'd9, 4'd0);
      push2_n(E_IDLE, 3);
      end_start();
      drain();

      // Async reset in the middle of A5
      begin_start(1'b0, 8'hA5, 4'd8, 4'd0);
      push2_bits(8'b101, 3);
      end_start();
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_async", {x2, v2, b2, d2}, E_IDLE);
      #1 reset_n = 1'b1;
      push2_n(E_IDLE, 3);
      drain();

`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
      // Injection at index 2 of 1100 on the first copy only
      inj_en  = 1'b1;
      inj_idx = 4'd2;
      begin_start(1'b0, 8'b0000_1100, 4'd4, 4'd1);
      push2_bits(8'b1000, 4);
      push2_n(E_GAP, 2);
      push2_bits(8'b1100, 4);
      q2.push_back(E_DONE);
      q2.push_back(E_IDLE);
      end_start();
      inj_en  = 1'b0;
      inj_idx = 4'd0;
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
